// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port main-memory arbiter between the icache and dcache
// line-fill / write-back paths. Dcache has fixed priority; a streak counter
// forces an icache grant after STARVE_LIMIT consecutive dcache wins while
// the icache is waiting. One transaction runs at a time: IDLE -> WAIT -> DONE.
module mem_arbiter #(
    parameter int unsigned LINE_W       = 128,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    // icache line-read port
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_rdata,
    // dcache line read/write port
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,
    // shared memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    // status
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    state_t            state_q,    state_d;
    owner_t            owner_q,    owner_d;
    logic [3:0]        streak_q,   streak_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              we_q,       we_d;
    logic [LINE_W-1:0] wdata_q,    wdata_d;
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;

    // True when the dcache wins arbitration in the current cycle.
    logic dc_wins;

    // Selection: lone requester wins; on contention dcache wins unless the
    // icache has already been passed over STARVE_LIMIT times in a row.
    always_comb begin
        dc_wins = dc_req && !(ic_req && (streak_q == STREAK_MAX));
    end

    // Next-state, request latching, streak tracking and read-data capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;

        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    state_d = WAIT;
                    if (dc_wins) begin
                        owner_d = OWN_DC;
                        addr_d  = dc_addr;
                        we_d    = dc_we;
                        wdata_d = dc_wdata;
                        // Count only wins that actually made the icache wait.
                        if (!ic_req) begin
                            streak_d = '0;
                        end else if (streak_q < STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end else begin
                        owner_d  = OWN_IC;
                        addr_d   = ic_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == OWN_DC) begin
                            dc_rdata_d = mem_rdata;
                        end else begin
                            ic_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IC;
            streak_q   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    // Control outputs decoded purely from registered state.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ic_ready = 1'b0;
        dc_ready = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            WAIT: begin
                mem_req = 1'b1;
                mem_we  = we_q;
            end
            DONE: begin
                ic_ready = (owner_q == OWN_IC);
                dc_ready = (owner_q == OWN_DC);
            end
            default: begin
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks for mem_arbiter, checked against a
// transaction-level reference (selection rule, streak count, line memory).
module tb_mem_arbiter;

    localparam int unsigned LW    = 128;
    localparam int unsigned AW    = 32;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_ready;
    logic [LW-1:0] ic_rdata;
    logic          dc_req = 1'b0;
    logic          dc_we = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [LW-1:0] dc_wdata = '0;
    logic          dc_ready;
    logic [LW-1:0] dc_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [LW-1:0] mem_rdata = '0;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory device contents (environment) and the expected-contents scoreboard.
    logic [LW-1:0] dev_mem [logic [AW-1:0]];
    logic [LW-1:0] ref_mem [logic [AW-1:0]];

    // Reference model state.
    int            m_streak = 0;
    logic [LW-1:0] m_ic_rdata = '0;
    logic [LW-1:0] m_dc_rdata = '0;

    typedef struct {
        logic          grant;
        logic [AW-1:0] addr;
        logic          we;
        logic [LW-1:0] wdata;
        bit            stable;
        bit            early_rdy;
        int            wait_cyc;
        logic          ic_rdy;
        logic          dc_rdy;
        logic          mreq_done;
        logic [LW-1:0] ic_rd;
        logic [LW-1:0] dc_rd;
        logic          busy_after;
        logic          rdy_after;
    } obs_t;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {a ^ 32'hA5A5_0000, a + 32'd1, ~a, {a[15:0], a[31:16]}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [LW-1:0] dev_read(input logic [AW-1:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return line_of(a);
    endfunction

    function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return line_of(a);
    endfunction

    // Arbitration rule: lone requester wins; contention goes to dcache unless
    // the icache has been passed over LIMIT times.
    function automatic bit pick_dc(input bit ic, input bit dc, input int streak);
        if (!ic) return dc;
        if (!dc) return 1'b0;
        return streak < LIMIT;
    endfunction

    function automatic int next_streak(input bit dc_won, input bit ic_pend, input int s);
        if (!dc_won || !ic_pend) return 0;
        return (s + 1 > LIMIT) ? LIMIT : s + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction starting in an IDLE cycle, acting as the memory with
    // the given latency, and records what the DUT showed. Owner's req is dropped
    // when its ready pulse is seen (unless keep_dc asks dcache to re-request).
    task automatic serve(input int lat, input bit keep_dc, output obs_t r);
        bit bail;
        r.grant = 0; r.addr = '0; r.we = 0; r.wdata = '0; r.stable = 1;
        r.early_rdy = 0; r.wait_cyc = 0; r.ic_rdy = 0; r.dc_rdy = 0;
        r.mreq_done = 0; r.ic_rd = '0; r.dc_rd = '0; r.busy_after = 0; r.rdy_after = 0;
        tick();
        r.grant = mem_req;
        r.addr  = mem_addr;
        r.we    = mem_we;
        r.wdata = mem_wdata;
        bail = 0;
        for (int i = 1; i <= lat && !bail; i++) begin
            if (mem_req !== 1'b1) begin
                bail = 1;
            end else begin
                r.wait_cyc++;
                if (mem_addr !== r.addr || mem_we !== r.we || mem_wdata !== r.wdata) r.stable = 0;
                if (ic_ready || dc_ready) r.early_rdy = 1;
                if (!ic_req) ic_addr = {$urandom_range(0, 255), 4'h0};
                if (!dc_req) begin
                    dc_addr  = {$urandom_range(0, 255), 4'h0};
                    dc_wdata = rand_line();
                    dc_we    = $urandom_range(0, 1);
                end
                mem_rdata = rand_line();
                if (i == lat) begin
                    mem_ready = 1'b1;
                    if (mem_we) dev_mem[mem_addr] = mem_wdata;
                    else mem_rdata = dev_read(mem_addr);
                end
                tick();
                mem_ready = 1'b0;
                mem_rdata = rand_line();
            end
        end
        r.ic_rdy    = ic_ready;
        r.dc_rdy    = dc_ready;
        r.mreq_done = mem_req;
        r.ic_rd     = ic_rdata;
        r.dc_rd     = dc_rdata;
        if (ic_ready) ic_req = 1'b0;
        if (dc_ready && !keep_dc) dc_req = 1'b0;
        tick();
        r.busy_after = busy;
        r.rdy_after  = ic_ready | dc_ready;
    endtask

    task automatic model_reset();
        m_streak   = 0;
        m_ic_rdata = '0;
        m_dc_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b exp 0", mem_we); end
        vectors++; if (ic_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ic_ready: got %b exp 0", ic_ready); end
        vectors++; if (dc_ready !== 1'b0) begin miscompares++; $display("FAIL reset_dc_ready: got %b exp 0", dc_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", busy); end
        vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
        vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h exp 0", mem_wdata); end
        vectors++; if (ic_rdata !== '0) begin miscompares++; $display("FAIL reset_ic_rdata: got %h exp 0", ic_rdata); end
        vectors++; if (dc_rdata !== '0) begin miscompares++; $display("FAIL reset_dc_rdata: got %h exp 0", dc_rdata); end
        #2 reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_icache_single();
        obs_t r;
        logic [LW-1:0] exp;
        ic_addr = 32'h40;
        ic_req  = 1'b1;
        exp = ref_read(32'h40);
        serve(3, 1'b0, r);
        m_streak   = next_streak(1'b0, 1'b1, m_streak);
        m_ic_rdata = exp;
        vectors++; if (r.grant !== 1'b1) begin miscompares++; $display("FAIL ic1_grant: got %b exp 1", r.grant); end
        vectors++; if (r.addr !== 32'h40) begin miscompares++; $display("FAIL ic1_mem_addr: got %h exp 40", r.addr); end
        vectors++; if (r.we !== 1'b0) begin miscompares++; $display("FAIL ic1_mem_we: got %b exp 0", r.we); end
        vectors++; if (r.wait_cyc != 3) begin miscompares++; $display("FAIL ic1_mem_req_cycles: got %0d exp 3", r.wait_cyc); end
        vectors++; if (!r.stable || r.early_rdy) begin miscompares++; $display("FAIL ic1_wait_hold: got stable=%0d early=%0d exp 1/0", r.stable, r.early_rdy); end
        vectors++; if (r.ic_rdy !== 1'b1 || r.dc_rdy !== 1'b0) begin miscompares++; $display("FAIL ic1_ready_cycle4: got ic=%b dc=%b exp 1/0", r.ic_rdy, r.dc_rdy); end
        vectors++; if (r.mreq_done !== 1'b0) begin miscompares++; $display("FAIL ic1_done_mem_req: got %b exp 0", r.mreq_done); end
        vectors++; if (r.ic_rd !== exp) begin miscompares++; $display("FAIL ic1_rdata: got %h exp %h", r.ic_rd, exp); end
        vectors++; if (r.busy_after !== 1'b0 || r.rdy_after !== 1'b0) begin miscompares++; $display("FAIL ic1_cycle5: got busy=%b rdy=%b exp 0/0", r.busy_after, r.rdy_after); end
        vectors++; if (ic_rdata !== exp) begin miscompares++; $display("FAIL ic1_rdata_hold: got %h exp %h", ic_rdata, exp); end
    endtask

    task automatic test_dc_write_read();
        obs_t r;
        logic [LW-1:0] wl;
        wl = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        dc_addr = 32'h100; dc_we = 1'b1; dc_wdata = wl; dc_req = 1'b1;
        serve(2, 1'b0, r);
        m_streak = next_streak(1'b1, 1'b0, m_streak);
        ref_mem[32'h100] = wl;
        vectors++; if (r.addr !== 32'h100 || r.we !== 1'b1) begin miscompares++; $display("FAIL dcw_addr_we: got %h/%b exp 100/1", r.addr, r.we); end
        vectors++; if (r.wdata !== wl) begin miscompares++; $display("FAIL dcw_mem_wdata: got %h exp %h", r.wdata, wl); end
        vectors++; if (r.dc_rdy !== 1'b1 || r.ic_rdy !== 1'b0) begin miscompares++; $display("FAIL dcw_ready: got dc=%b ic=%b exp 1/0", r.dc_rdy, r.ic_rdy); end
        vectors++; if (r.dc_rd !== m_dc_rdata) begin miscompares++; $display("FAIL dcw_rdata_unchanged: got %h exp %h", r.dc_rd, m_dc_rdata); end
        dc_we = 1'b0; dc_req = 1'b1;
        serve(1, 1'b0, r);
        m_streak   = next_streak(1'b1, 1'b0, m_streak);
        m_dc_rdata = ref_read(32'h100);
        vectors++; if (r.we !== 1'b0 || r.dc_rdy !== 1'b1) begin miscompares++; $display("FAIL dcr_we_ready: got we=%b rdy=%b exp 0/1", r.we, r.dc_rdy); end
        vectors++; if (r.dc_rd !== wl) begin miscompares++; $display("FAIL dcr_readback: got %h exp %h", r.dc_rd, wl); end
    endtask

    task automatic test_simultaneous();
        obs_t r1, r2;
        ic_addr = 32'h200; ic_req = 1'b1;
        dc_addr = 32'h300; dc_we = 1'b0; dc_req = 1'b1;
        serve(2, 1'b0, r1);
        m_streak   = next_streak(1'b1, 1'b1, m_streak);
        m_dc_rdata = ref_read(32'h300);
        serve(1, 1'b0, r2);
        m_streak   = next_streak(1'b0, 1'b1, m_streak);
        m_ic_rdata = ref_read(32'h200);
        vectors++; if (r1.dc_rdy !== 1'b1 || r1.addr !== 32'h300) begin miscompares++; $display("FAIL sim_dc_first: got rdy=%b addr=%h exp 1/300", r1.dc_rdy, r1.addr); end
        vectors++; if (r1.dc_rd !== m_dc_rdata) begin miscompares++; $display("FAIL sim_dc_rdata: got %h exp %h", r1.dc_rd, m_dc_rdata); end
        vectors++; if (r2.grant !== 1'b1 || r2.addr !== 32'h200) begin miscompares++; $display("FAIL sim_ic_next: got grant=%b addr=%h exp 1/200", r2.grant, r2.addr); end
        vectors++; if (r2.ic_rdy !== 1'b1 || r2.ic_rd !== m_ic_rdata) begin miscompares++; $display("FAIL sim_ic_done: got rdy=%b data=%h exp 1/%h", r2.ic_rdy, r2.ic_rd, m_ic_rdata); end
    endtask

    // Dcache keeps re-requesting while icache waits; icache must win every
    // (LIMIT+1)-th grant, and the count restarts after each icache win.
    task automatic test_starvation();
        obs_t r;
        bit exp_ic;
        logic [AW-1:0] a;
        ic_addr = 32'h480; ic_req = 1'b1;
        dc_we = 1'b0; dc_req = 1'b1;
        for (int k = 0; k < 2 * (LIMIT + 1); k++) begin
            ic_req  = 1'b1;
            dc_addr = 32'h1000 + 32'(k) * 32'h10;
            exp_ic  = ((k % (LIMIT + 1)) == LIMIT);
            a = exp_ic ? ic_addr : dc_addr;
            serve($urandom_range(1, 3), 1'b1, r);
            m_streak = next_streak(!exp_ic, 1'b1, m_streak);
            if (exp_ic) m_ic_rdata = ref_read(a); else m_dc_rdata = ref_read(a);
            vectors++; if (r.ic_rdy !== exp_ic || r.dc_rdy !== !exp_ic) begin miscompares++; $display("FAIL starve_owner_k%0d: got ic=%b dc=%b exp ic=%b", k, r.ic_rdy, r.dc_rdy, exp_ic); end
            vectors++; if (r.addr !== a) begin miscompares++; $display("FAIL starve_addr_k%0d: got %h exp %h", k, r.addr, a); end
        end
        dc_req = 1'b0;
        ic_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        obs_t r;
        bit exp_ic;
        logic [AW-1:0] a;
        ic_addr = 32'h600; ic_req = 1'b1;
        dc_addr = 32'h700; dc_we = 1'b0; dc_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            serve(1, 1'b1, r);
            m_streak   = next_streak(1'b1, 1'b1, m_streak);
            m_dc_rdata = ref_read(32'h700);
        end
        tick();
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rmw_wait_entered: got %b exp 1", mem_req); end
        tick();
        reset = 1'b1;
        #1;
        vectors++; if (mem_req !== 1'b0 || busy !== 1'b0 || dc_ready !== 1'b0) begin miscompares++; $display("FAIL rmw_async_clear: got req=%b busy=%b rdy=%b exp 0/0/0", mem_req, busy, dc_ready); end
        vectors++; if (dc_rdata !== '0 || mem_addr !== '0) begin miscompares++; $display("FAIL rmw_async_data: got rdata=%h addr=%h exp 0/0", dc_rdata, mem_addr); end
        tick();
        #2 reset = 1'b0;
        model_reset();
        tick();
        for (int k = 0; k <= LIMIT; k++) begin
            ic_req  = 1'b1;
            dc_addr = 32'h800 + 32'(k) * 32'h10;
            exp_ic  = (k == LIMIT);
            a = exp_ic ? ic_addr : dc_addr;
            serve(2, 1'b1, r);
            m_streak = next_streak(!exp_ic, 1'b1, m_streak);
            if (exp_ic) m_ic_rdata = ref_read(a); else m_dc_rdata = ref_read(a);
            vectors++; if (r.ic_rdy !== exp_ic || r.dc_rdy !== !exp_ic) begin miscompares++; $display("FAIL rmw_post_owner_k%0d: got ic=%b dc=%b exp ic=%b", k, r.ic_rdy, r.dc_rdy, exp_ic); end
            if (exp_ic) begin
                vectors++; if (r.ic_rd !== m_ic_rdata) begin miscompares++; $display("FAIL rmw_post_ic_rdata: got %h exp %h", r.ic_rd, m_ic_rdata); end
            end
        end
        dc_req = 1'b0;
        ic_req = 1'b0;
        tick();
    endtask

    task automatic test_fast_and_stray();
        obs_t r;
        ic_req = 1'b0; dc_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = rand_line();
        tick();
        mem_rdata = rand_line();
        tick();
        vectors++; if (busy !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL stray_state: got busy=%b req=%b exp 0/0", busy, mem_req); end
        vectors++; if (ic_ready !== 1'b0 || dc_ready !== 1'b0) begin miscompares++; $display("FAIL stray_ready: got ic=%b dc=%b exp 0/0", ic_ready, dc_ready); end
        vectors++; if (ic_rdata !== m_ic_rdata || dc_rdata !== m_dc_rdata) begin miscompares++; $display("FAIL stray_rdata: got %h/%h exp %h/%h", ic_rdata, dc_rdata, m_ic_rdata, m_dc_rdata); end
        mem_ready = 1'b0;
        ic_addr = 32'h840; ic_req = 1'b1;
        serve(1, 1'b0, r);
        m_streak   = next_streak(1'b0, 1'b1, m_streak);
        m_ic_rdata = ref_read(32'h840);
        vectors++; if (r.wait_cyc != 1 || r.ic_rdy !== 1'b1) begin miscompares++; $display("FAIL fast_n1: got wait=%0d rdy=%b exp 1/1", r.wait_cyc, r.ic_rdy); end
        vectors++; if (r.ic_rd !== m_ic_rdata) begin miscompares++; $display("FAIL fast_n1_rdata: got %h exp %h", r.ic_rd, m_ic_rdata); end
    endtask

    task automatic test_random();
        obs_t r;
        bit exp_dc, ic_pend, exp_we;
        int lat;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wdata;
        for (int n = 0; n < 150; n++) begin
            if (!ic_req && $urandom_range(0, 1)) begin
                ic_addr = 32'h2000 | {$urandom_range(0, 15), 4'h0};
                ic_req  = 1'b1;
            end
            if (!dc_req && ($urandom_range(0, 2) != 0 || !ic_req)) begin
                dc_addr  = 32'h2000 | {$urandom_range(0, 15), 4'h0};
                dc_we    = $urandom_range(0, 1);
                dc_wdata = rand_line();
                dc_req   = 1'b1;
            end
            ic_pend   = ic_req;
            exp_dc    = pick_dc(ic_req, dc_req, m_streak);
            exp_addr  = exp_dc ? dc_addr : ic_addr;
            exp_we    = exp_dc ? dc_we : 1'b0;
            exp_wdata = dc_wdata;
            if (exp_we) ref_mem[exp_addr] = exp_wdata;
            else if (exp_dc) m_dc_rdata = ref_read(exp_addr);
            else m_ic_rdata = ref_read(exp_addr);
            m_streak = next_streak(exp_dc, ic_pend, m_streak);
            lat = $urandom_range(1, 4);
            serve(lat, 1'b0, r);
            vectors++; if (r.dc_rdy !== exp_dc || r.ic_rdy !== !exp_dc) begin miscompares++; $display("FAIL rnd_owner_%0d: got dc=%b ic=%b exp dc=%b", n, r.dc_rdy, r.ic_rdy, exp_dc); end
            vectors++; if (r.addr !== exp_addr || r.we !== exp_we) begin miscompares++; $display("FAIL rnd_addr_we_%0d: got %h/%b exp %h/%b", n, r.addr, r.we, exp_addr, exp_we); end
            if (exp_we) begin
                vectors++; if (r.wdata !== exp_wdata) begin miscompares++; $display("FAIL rnd_wdata_%0d: got %h exp %h", n, r.wdata, exp_wdata); end
            end
            vectors++; if (r.wait_cyc != lat || !r.stable || r.early_rdy) begin miscompares++; $display("FAIL rnd_wait_%0d: got cyc=%0d stable=%0d early=%0d exp %0d/1/0", n, r.wait_cyc, r.stable, r.early_rdy, lat); end
            vectors++; if (r.ic_rd !== m_ic_rdata || r.dc_rd !== m_dc_rdata) begin miscompares++; $display("FAIL rnd_rdata_%0d: got %h/%h exp %h/%h", n, r.ic_rd, r.dc_rd, m_ic_rdata, m_dc_rdata); end
            vectors++; if (r.busy_after !== 1'b0 || r.rdy_after !== 1'b0) begin miscompares++; $display("FAIL rnd_after_%0d: got busy=%b rdy=%b exp 0/0", n, r.busy_after, r.rdy_after); end
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_icache_single();
        test_dc_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_wait();
        test_fast_and_stray();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
